// File: rtl/touch_button_ctrl.sv
// Touch-panel hit-test sequencer: latches a sample, scans four rectangles through one
// shared comparator, resolves overlap by lowest index, and debounces each button.
module touch_button_ctrl #(
    parameter logic [39:0] XLO     = {10'd0,   10'd400, 10'd0,  10'd184},
    parameter logic [39:0] XHI     = {10'd639, 10'd639, 10'd99, 10'd326},
    parameter logic [35:0] YLO     = {9'd440,  9'd0,    9'd0,   9'd121},
    parameter logic [35:0] YHI     = {9'd479,  9'd99,   9'd99,  9'd219},
    parameter logic [3:0]  DEB_LEN = 4'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_stb,
    input  logic       touch,
    input  logic [9:0] tor_x,
    input  logic [8:0] tor_y,
    output logic       busy,
    output logic [1:0] scan_idx,
    output logic [3:0] btn_state,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release,
    output logic       drop
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       touch_q, touch_d;
    logic [3:0] hit_q, hit_d;
    logic [3:0] btn_q, btn_d;
    logic [3:0] press_q, press_d;
    logic [3:0] release_q, release_d;
    logic       drop_q, drop_d;

    logic [9:0] xlo_sel, xhi_sel;
    logic [8:0] ylo_sel, yhi_sel;
    logic       in_rect;
    logic [3:0] eff;

    // One comparator shared by all regions; bounds are muxed by the scan index.
    assign xlo_sel = XLO[{3'd0, idx_q} * 5'd10 +: 10];
    assign xhi_sel = XHI[{3'd0, idx_q} * 5'd10 +: 10];
    assign ylo_sel = YLO[{3'd0, idx_q} * 5'd9 +: 9];
    assign yhi_sel = YHI[{3'd0, idx_q} * 5'd9 +: 9];

    assign in_rect = touch_q
                   & (x_q >= xlo_sel) & (x_q <= xhi_sel)
                   & (y_q >= ylo_sel) & (y_q <= yhi_sel);

    // Isolate the lowest set hit bit: lower index wins on overlap.
    assign eff = hit_q & (~hit_q + 4'd1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        touch_d = touch_q;
        hit_d   = hit_q;
        drop_d  = sample_stb & (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (sample_stb) begin
                    x_d     = tor_x;
                    y_d     = tor_y;
                    touch_d = touch;
                    hit_d   = 4'd0;
                    idx_d   = 2'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                hit_d[idx_q] = in_rect;
                if (idx_q == 2'd3) begin
                    state_d = UPDATE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            UPDATE: begin
                idx_d   = 2'd0;
                state_d = IDLE;
            end
            default: begin
                idx_d   = 2'd0;
                state_d = IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_deb
            logic [3:0] cnt_q, cnt_d;
            logic [3:0] cnt_inc;
            logic       flip;

            assign cnt_inc = cnt_q + 4'd1;

            always_comb begin
                cnt_d = cnt_q;
                flip  = 1'b0;
                if (state_q == UPDATE) begin
                    if (eff[gi] != btn_q[gi]) begin
                        if (cnt_inc == DEB_LEN) begin
                            flip  = 1'b1;
                            cnt_d = 4'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q <= 4'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign btn_d[gi]     = btn_q[gi] ^ flip;
            assign press_d[gi]   = flip & ~btn_q[gi];
            assign release_d[gi] = flip & btn_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            x_q       <= 10'd0;
            y_q       <= 9'd0;
            touch_q   <= 1'b0;
            hit_q     <= 4'd0;
            btn_q     <= 4'd0;
            press_q   <= 4'd0;
            release_q <= 4'd0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            x_q       <= x_d;
            y_q       <= y_d;
            touch_q   <= touch_d;
            hit_q     <= hit_d;
            btn_q     <= btn_d;
            press_q   <= press_d;
            release_q <= release_d;
            drop_q    <= drop_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign scan_idx    = idx_q;
    assign btn_state   = btn_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign drop        = drop_q;

endmodule
